// File: rtl/dot_matrix_scanner_if.sv
// dot_matrix_scanner_if: frame-buffer write port, mode select and LED drive lines
interface dot_matrix_scanner_if #(
   parameter int PANELS = 2,
   parameter int ROWS   = 8,
   parameter int COLS   = 8
);
   localparam int PW = PANELS > 1 ? $clog2(PANELS) : 1;
   localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
   logic                   wr_en;
   logic                   wr_page;
   logic [PW-1:0]          wr_panel;
   logic [RW-1:0]          wr_row;
   logic [COLS-1:0]        wr_data;
   logic [1:0]             mode;
   logic [ROWS-1:0]        dot_row;
   logic [PANELS*COLS-1:0] dot_col;
   logic                   frame_start;
   modport master (
      output wr_en, wr_page, wr_panel, wr_row, wr_data, mode,
      input  dot_row, dot_col, frame_start
   );
   modport slave (
      input  wr_en, wr_page, wr_panel, wr_row, wr_data, mode,
      output dot_row, dot_col, frame_start
   );
endinterface

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: two-page frame buffer scanned row by row onto shared-row LED matrices
// Mode and blink phase are only adopted at frame boundaries so a frame is never torn.
module dot_matrix_scanner #(
   parameter int PANELS    = 2,
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int SCAN_DIV  = 10,
   parameter int BLINK_DIV = 2500
) (
   input logic              clk_10000Hz,
   input logic              reset,
   dot_matrix_scanner_if.slave bus
);
   localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [COLS-1:0]        fb [2][PANELS][ROWS];
   logic [SW-1:0]          slot;
   logic [RW-1:0]          row_idx;
   logic [BW-1:0]          blink_cnt;
   logic                   blink_phase, shown_phase;
   logic [1:0]             active_mode;
   logic                   boundary, blank, page;
   logic [ROWS-1:0]        row_nx;
   logic [PANELS*COLS-1:0] col_nx;

   always_comb begin
      boundary = slot == '0 && row_idx == '0;
      blank    = slot == '0 || active_mode == 2'b11;
      page     = active_mode[1] ? shown_phase : active_mode[0];
      row_nx   = blank ? '1 : ~(ROWS'(1) << (ROW_LAST - row_idx));
      col_nx   = '0;
      for (int p = 0; p < PANELS; p++)
         col_nx[(PANELS-1-p)*COLS +: COLS] = blank ? '0 : fb[page][p][row_idx];
   end

   always_ff @(posedge clk_10000Hz) begin
      if (!reset) begin
         slot            <= '0;
         row_idx         <= '0;
         blink_cnt       <= '0;
         blink_phase     <= 1'b0;
         shown_phase     <= 1'b0;
         active_mode     <= 2'b11;
         bus.dot_row     <= '1;
         bus.dot_col     <= '0;
         bus.frame_start <= 1'b0;
         for (int g = 0; g < 2; g++)
            for (int p = 0; p < PANELS; p++)
               for (int r = 0; r < ROWS; r++)
                  fb[g][p][r] <= '0;
      end else begin
         slot      <= slot == SLOT_LAST ? '0 : slot + SW'(1);
         blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + BW'(1);
         if (slot == SLOT_LAST)
            row_idx <= row_idx == ROW_LAST ? '0 : row_idx + RW'(1);
         if (blink_cnt == BLINK_LAST)
            blink_phase <= ~blink_phase;
         if (boundary) begin
            active_mode <= bus.mode;
            shown_phase <= blink_phase;
         end
         bus.dot_row     <= row_nx;
         bus.dot_col     <= col_nx;
         bus.frame_start <= boundary;
         // out-of-range addresses are dropped rather than aliased onto real rows/panels
         if (bus.wr_en && 32'(bus.wr_panel) < PANELS && 32'(bus.wr_row) < ROWS)
            fb[bus.wr_page][bus.wr_panel][bus.wr_row] <= bus.wr_data;
      end
   end
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb_dot_matrix_scanner: random writes and directed mode/reset steps on two configurations,
// checked every cycle against a cycle-count based reference model.
module tb_dot_matrix_scanner;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] mode = 2'b00;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   dot_matrix_scanner_if #(.PANELS(2), .ROWS(8), .COLS(8)) ia ();
   dot_matrix_scanner_if #(.PANELS(3), .ROWS(6), .COLS(4)) ib ();
   assign ia.mode = mode;
   assign ib.mode = mode;

   dot_matrix_scanner #(.PANELS(2), .ROWS(8), .COLS(8), .SCAN_DIV(10), .BLINK_DIV(2500)) ua (
      .clk_10000Hz(clk), .reset(reset), .bus(ia.slave));
   dot_matrix_scanner #(.PANELS(3), .ROWS(6), .COLS(4), .SCAN_DIV(2), .BLINK_DIV(200)) ub (
      .clk_10000Hz(clk), .reset(reset), .bus(ib.slave));

   int np[2] = '{2, 3};
   int nr[2] = '{8, 6};
   int nc[2] = '{8, 4};
   int ns[2] = '{10, 2};
   int nb[2] = '{2500, 200};
   logic [7:0] fbm [2][2][3][8];
   int n[2], am[2], sh[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // n = edges since reset release; scan position and blink phase follow from it arithmetically
   task automatic edge_update(input int d, input logic rst_n, input logic [1:0] md,
                              input logic we, input int pg, input int pn, input int rw,
                              input logic [7:0] dat, input logic [31:0] orow,
                              input logic [31:0] ocol, input logic ofs);
      logic [31:0] er, ec, rmask, cmask;
      logic        ef;
      int          sl, ro, page;
      rmask = (32'd1 << nr[d]) - 32'd1;
      cmask = (32'd1 << nc[d]) - 32'd1;
      er = rmask;
      ec = '0;
      ef = 1'b0;
      if (!rst_n) begin
         n[d] = 0; am[d] = 3; sh[d] = 0;
         for (int g = 0; g < 2; g++)
            for (int p = 0; p < 3; p++)
               for (int r = 0; r < 8; r++)
                  fbm[d][g][p][r] = '0;
      end else begin
         sl = n[d] % ns[d];
         ro = (n[d] / ns[d]) % nr[d];
         page = am[d] == 2 ? sh[d] : am[d];
         ef = (n[d] % (ns[d] * nr[d])) == 0;
         if (sl != 0 && am[d] != 3) begin
            er = rmask & ~(32'd1 << (nr[d] - 1 - ro));
            for (int p = 0; p < np[d]; p++)
               ec |= (32'(fbm[d][page][p][ro]) & cmask) << ((np[d] - 1 - p) * nc[d]);
         end
         if (ef) begin
            am[d] = int'(md);
            sh[d] = (n[d] / nb[d]) % 2;
         end
         if (we && pn < np[d] && rw < nr[d]) fbm[d][pg][pn][rw] = dat;
         n[d]++;
      end
      chk($sformatf("dot_row%0d", d), orow, er);
      chk($sformatf("dot_col%0d", d), ocol, ec);
      chk($sformatf("frame_start%0d", d), 32'(ofs), 32'(ef));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_update(0, reset, mode, ia.wr_en, int'(ia.wr_page), int'(ia.wr_panel), int'(ia.wr_row),
                  8'(ia.wr_data), 32'(ia.dot_row), 32'(ia.dot_col), ia.frame_start);
      edge_update(1, reset, mode, ib.wr_en, int'(ib.wr_page), int'(ib.wr_panel), int'(ib.wr_row),
                  8'(ib.wr_data), 32'(ib.dot_row), 32'(ib.dot_col), ib.frame_start);
   endtask

   task automatic idle_wr();
      ia.wr_en = 1'b0; ia.wr_page = 1'b0; ia.wr_panel = '0; ia.wr_row = '0; ia.wr_data = '0;
      ib.wr_en = 1'b0; ib.wr_page = 1'b0; ib.wr_panel = '0; ib.wr_row = '0; ib.wr_data = '0;
   endtask

   task automatic run(input int cycles, input int pct);
      for (int i = 0; i < cycles; i++) begin
         ia.wr_en = $urandom_range(0, 99) < pct;
         ia.wr_page = 1'($urandom_range(0, 1));
         ia.wr_panel = 1'($urandom_range(0, 1));
         ia.wr_row = 3'($urandom_range(0, 7));
         ia.wr_data = 8'($urandom);
         ib.wr_en = $urandom_range(0, 99) < pct;
         ib.wr_page = 1'($urandom_range(0, 1));
         ib.wr_panel = 2'($urandom_range(0, 3));
         ib.wr_row = 3'($urandom_range(0, 7));
         ib.wr_data = 4'($urandom);
         step();
      end
      idle_wr();
   endtask

   task automatic wait_row_a(input logic [7:0] pat, input string tag);
      logic found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         found = ia.dot_row == pat;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_fs_a(input string tag);
      logic found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         found = ia.frame_start;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      idle_wr();
      repeat (3) step();
      chk("rst_row", 32'(ia.dot_row), 32'h00FF);
      chk("rst_col", 32'(ia.dot_col), 32'h0000);
      chk("rst_fs", 32'(ia.frame_start), 32'd0);
      reset = 1'b1;
      step();
      chk("first_fs", 32'(ia.frame_start), 32'd1);
      ia.wr_en = 1'b1; ia.wr_page = 1'b0; ia.wr_panel = 1'b0; ia.wr_row = 3'd0; ia.wr_data = 8'h3C;
      step();
      ia.wr_panel = 1'b1; ia.wr_data = 8'h81;
      step();
      idle_wr();
      wait_fs_a("wait_fs_static");
      chk("static_blank_row", 32'(ia.dot_row), 32'h00FF);
      chk("static_blank_col", 32'(ia.dot_col), 32'h0000);
      step();
      chk("static_row0", 32'(ia.dot_row), 32'h007F);
      chk("static_col0", 32'(ia.dot_col), 32'h3C81);
      run(300, 50);
      wait_row_a(8'hEF, "wait_row3");
      mode = 2'b01;
      run(200, 30);
      mode = 2'b10;
      run(5400, 20);
      mode = 2'b11;
      run(200, 50);
      ib.wr_en = 1'b1; ib.wr_page = 1'b0; ib.wr_panel = 2'd3; ib.wr_row = 3'd0; ib.wr_data = 4'hF;
      step();
      ib.wr_panel = 2'd0; ib.wr_row = 3'd6;
      step();
      idle_wr();
      mode = 2'b00;
      run(200, 50);
      wait_row_a(8'hFB, "wait_row5");
      reset = 1'b0;
      step();
      step();
      chk("midrst_row", 32'(ia.dot_row), 32'h00FF);
      chk("midrst_col", 32'(ia.dot_col), 32'h0000);
      reset = 1'b1;
      step();
      chk("midrst_fs", 32'(ia.frame_start), 32'd1);
      wait_fs_a("wait_fs_after_rst");
      step();
      chk("cleared_row0", 32'(ia.dot_row), 32'h007F);
      chk("cleared_col0", 32'(ia.dot_col), 32'h0000);
      run(200, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
